// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester handshakes and split SRAM bus for sram_arbiter
// Purpose: bundles the three requester ports and the SRAM pad-side signals.
// Signal groups:
//   display   : i_disp_req, i_disp_addr -> o_disp_gnt, o_disp_rvalid, o_disp_rdata
//   loader    : i_load_req, i_load_addr, i_load_wdata -> o_load_gnt
//   processor : i_proc_req, i_proc_we, i_proc_addr, i_proc_wdata
//               -> o_proc_gnt, o_proc_rvalid, o_proc_rdata
//   sram      : o_sram_addr, o_sram_dq, o_sram_dq_oe, o_sram_*_n <- i_sram_dq
//   status    : o_busy
// Modports: slave = arbiter side, master = requesters and SRAM pad side.
interface sram_arbiter_if;
  logic        i_disp_req;
  logic [19:0] i_disp_addr;
  logic        o_disp_gnt;
  logic        o_disp_rvalid;
  logic [15:0] o_disp_rdata;

  logic        i_load_req;
  logic [19:0] i_load_addr;
  logic [15:0] i_load_wdata;
  logic        o_load_gnt;

  logic        i_proc_req;
  logic        i_proc_we;
  logic [19:0] i_proc_addr;
  logic [15:0] i_proc_wdata;
  logic        o_proc_gnt;
  logic        o_proc_rvalid;
  logic [15:0] o_proc_rdata;

  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq;
  logic        o_sram_ce_n;
  logic        o_sram_oe_n;
  logic        o_sram_we_n;
  logic        o_sram_lb_n;
  logic        o_sram_ub_n;

  logic        o_busy;

  modport slave (
    input  i_disp_req, i_disp_addr,
    output o_disp_gnt, o_disp_rvalid, o_disp_rdata,
    input  i_load_req, i_load_addr, i_load_wdata,
    output o_load_gnt,
    input  i_proc_req, i_proc_we, i_proc_addr, i_proc_wdata,
    output o_proc_gnt, o_proc_rvalid, o_proc_rdata,
    output o_sram_addr, o_sram_dq, o_sram_dq_oe,
    input  i_sram_dq,
    output o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n,
    output o_busy
  );

  modport master (
    output i_disp_req, i_disp_addr,
    input  o_disp_gnt, o_disp_rvalid, o_disp_rdata,
    output i_load_req, i_load_addr, i_load_wdata,
    input  o_load_gnt,
    output i_proc_req, i_proc_we, i_proc_addr, i_proc_wdata,
    input  o_proc_gnt, o_proc_rvalid, o_proc_rdata,
    input  o_sram_addr, o_sram_dq, o_sram_dq_oe,
    output i_sram_dq,
    input  o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n,
    input  o_busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-word arbiter owning the external 1Mx16 SRAM
// Purpose: serialises display reads, loader writes and processor reads/writes
//   onto one SRAM. Display has fixed priority; loader and processor share a
//   round-robin pointer. Each transaction is ACCESS_CYCLES strobe cycles plus
//   one TURN cycle that holds address/data after the strobes rise.
// Ports:
//   i_clk   : system clock
//   i_rst_n : synchronous reset, active high (asserted = 1)
//   bus     : sram_arbiter_if.slave - requester handshakes, SRAM pins, o_busy
// Parameter:
//   ACCESS_CYCLES : strobe-active cycles per transaction, 1..15
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sram_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
  typedef enum logic [1:0] {WIN_DISP, WIN_LOAD, WIN_PROC} win_t;

  state_t      state, state_nxt;
  win_t        win_q, win_nxt;
  logic [3:0]  cnt;
  logic        rr_q, rr_nxt;          // 0: loader favoured, 1: processor favoured
  logic        grant;
  logic [19:0] addr_q, addr_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic        we_q, we_nxt;
  logic        any_req, pick_load, read_done;

  logic        disp_gnt_q, load_gnt_q, proc_gnt_q;
  logic        disp_rvalid_q, proc_rvalid_q;
  logic [15:0] disp_rdata_q, proc_rdata_q;
  logic        ce_n_q, oe_n_q, we_n_q, dq_oe_q;

  assign any_req   = bus.i_disp_req || bus.i_load_req || bus.i_proc_req;
  // Loader wins when alone, or when both contend and the pointer favours it.
  assign pick_load = bus.i_load_req && (!bus.i_proc_req || !rr_q);
  // Data is captured on the edge that closes the last strobe cycle of a read.
  assign read_done = (state == ACCESS) && (cnt == LAST_CNT) && !we_q;

  always_comb begin
    state_nxt = state;
    win_nxt   = win_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    we_nxt    = we_q;
    rr_nxt    = rr_q;
    grant     = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (any_req) begin
          state_nxt = ACCESS;
          grant     = 1'b1;
          if (bus.i_disp_req) begin
            win_nxt   = WIN_DISP;
            addr_nxt  = bus.i_disp_addr;
            wdata_nxt = 16'h0000;
            we_nxt    = 1'b0;
          end else if (pick_load) begin
            win_nxt   = WIN_LOAD;
            addr_nxt  = bus.i_load_addr;
            wdata_nxt = bus.i_load_wdata;
            we_nxt    = 1'b1;
            rr_nxt    = 1'b1;
          end else begin
            win_nxt   = WIN_PROC;
            addr_nxt  = bus.i_proc_addr;
            wdata_nxt = bus.i_proc_wdata;
            we_nxt    = bus.i_proc_we;
            rr_nxt    = 1'b0;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == LAST_CNT) begin
          state_nxt = TURN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state         <= IDLE;
      win_q         <= WIN_DISP;
      cnt           <= 4'd0;
      rr_q          <= 1'b0;
      addr_q        <= 20'h00000;
      wdata_q       <= 16'h0000;
      we_q          <= 1'b0;
      disp_gnt_q    <= 1'b0;
      load_gnt_q    <= 1'b0;
      proc_gnt_q    <= 1'b0;
      disp_rvalid_q <= 1'b0;
      proc_rvalid_q <= 1'b0;
      disp_rdata_q  <= 16'h0000;
      proc_rdata_q  <= 16'h0000;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      dq_oe_q       <= 1'b0;
    end else begin
      state   <= state_nxt;
      win_q   <= win_nxt;
      rr_q    <= rr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      we_q    <= we_nxt;
      cnt     <= (state == ACCESS && state_nxt == ACCESS) ? cnt + 4'd1 : 4'd0;

      disp_gnt_q <= grant && (win_nxt == WIN_DISP);
      load_gnt_q <= grant && (win_nxt == WIN_LOAD);
      proc_gnt_q <= grant && (win_nxt == WIN_PROC);

      disp_rvalid_q <= read_done && (win_q == WIN_DISP);
      proc_rvalid_q <= read_done && (win_q == WIN_PROC);
      if (read_done && win_q == WIN_DISP) disp_rdata_q <= bus.i_sram_dq;
      if (read_done && win_q == WIN_PROC) proc_rdata_q <= bus.i_sram_dq;

      // Pins are registered from the next state so they change cleanly on
      // the edge; TURN keeps ce_n/dq_oe from ACCESS while strobes rise.
      ce_n_q  <= (state_nxt == IDLE);
      oe_n_q  <= !((state_nxt == ACCESS) && !we_nxt);
      we_n_q  <= !((state_nxt == ACCESS) && we_nxt);
      dq_oe_q <= (state_nxt != IDLE) && we_nxt;
    end
  end

  assign bus.o_disp_gnt    = disp_gnt_q;
  assign bus.o_load_gnt    = load_gnt_q;
  assign bus.o_proc_gnt    = proc_gnt_q;
  assign bus.o_disp_rvalid = disp_rvalid_q;
  assign bus.o_proc_rvalid = proc_rvalid_q;
  assign bus.o_disp_rdata  = disp_rdata_q;
  assign bus.o_proc_rdata  = proc_rdata_q;
  assign bus.o_sram_addr   = addr_q;
  assign bus.o_sram_dq     = wdata_q;
  assign bus.o_sram_dq_oe  = dq_oe_q;
  assign bus.o_sram_ce_n   = ce_n_q;
  assign bus.o_sram_lb_n   = ce_n_q;
  assign bus.o_sram_ub_n   = ce_n_q;
  assign bus.o_sram_oe_n   = oe_n_q;
  assign bus.o_sram_we_n   = we_n_q;
  assign bus.o_busy        = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;
  localparam int AC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rr_fav  = 1'b0;   // 0: loader is next when both contend

  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] ref_mem  [logic [19:0]];

  function automatic logic [15:0] bg(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A ^ {12'h000, a[19:16]};
  endfunction

  function automatic logic [15:0] sram_rd(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : bg(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  // SRAM device model: read data shows while CE/OE are low; writes land on
  // each clock edge while CE/WE are low and the bus is driven.
  always @(negedge clk) begin
    if (!bus.o_sram_ce_n && !bus.o_sram_oe_n) bus.i_sram_dq = sram_rd(bus.o_sram_addr);
    else bus.i_sram_dq = 16'hDEAD;
  end

  always @(posedge clk) begin
    if (!bus.o_sram_ce_n && !bus.o_sram_we_n && bus.o_sram_dq_oe)
      sram_mem[bus.o_sram_addr] = bus.o_sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_ctl"}, {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_lb_n,
                          bus.o_sram_ub_n, bus.o_sram_dq_oe, bus.o_busy}, 32'b1111100);
    check({tag, "_pulses"}, {bus.o_disp_gnt, bus.o_load_gnt, bus.o_proc_gnt,
                             bus.o_disp_rvalid, bus.o_proc_rvalid}, 32'h0);
    check({tag, "_addr"}, bus.o_sram_addr, 32'h0);
    check({tag, "_dq"}, bus.o_sram_dq, 32'h0);
    check({tag, "_rdata"}, {bus.o_disp_rdata, bus.o_proc_rdata}, 32'h0);
  endtask

  // Loader and processor traffic with requesters holding req while more work
  // is queued. Expected grant slots come from the alternation rule alone.
  task automatic run_lp(input string tag, input int n_l, input int n_p,
                        input bit reads_only, input logic [19:0] base);
    logic [19:0] la[$];
    logic [19:0] pa[$];
    logic [15:0] ld[$];
    logic [15:0] pd[$];
    logic        pw[$];
    logic [19:0] touched[$];
    int          order[$];
    int          nl_left, np_left, li, pi, ml, mp, total, k, pend_cyc;
    logic [15:0] pend_data;
    logic [1:0]  exp_g;
    for (int i = 0; i < n_l; i++) begin
      la.push_back(base + 20'($urandom_range(0, 16 * n_p + 15)));
      ld.push_back(16'($urandom));
    end
    for (int i = 0; i < n_p; i++) begin
      pa.push_back(base + 20'(16 * i) + 20'($urandom_range(0, 15)));
      pd.push_back(16'($urandom));
      pw.push_back(reads_only ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    nl_left = n_l;
    np_left = n_p;
    while (nl_left + np_left > 0) begin
      if (nl_left > 0 && (np_left == 0 || rr_fav == 1'b0)) begin
        order.push_back(0); nl_left--; rr_fav = 1'b1;
      end else begin
        order.push_back(1); np_left--; rr_fav = 1'b0;
      end
    end
    li = 0; pi = 0; ml = 0; mp = 0; pend_cyc = -1; pend_data = 16'h0;
    total = n_l + n_p;
    if (n_l > 0) begin
      bus.i_load_req = 1'b1; bus.i_load_addr = la[0]; bus.i_load_wdata = ld[0];
    end
    if (n_p > 0) begin
      bus.i_proc_req = 1'b1; bus.i_proc_addr = pa[0]; bus.i_proc_wdata = pd[0]; bus.i_proc_we = pw[0];
    end
    for (int c = 1; c <= total * (AC + 1) + AC + 2; c++) begin
      step();
      exp_g = 2'b00;
      if ((c - 1) % (AC + 1) == 0 && (c - 1) / (AC + 1) < total) begin
        k = (c - 1) / (AC + 1);
        if (order[k] == 0) begin
          exp_g = 2'b10;
          ref_mem[la[ml]] = ld[ml];
          touched.push_back(la[ml]);
          ml++;
        end else begin
          exp_g = 2'b01;
          if (pw[mp]) begin
            ref_mem[pa[mp]] = pd[mp];
            touched.push_back(pa[mp]);
          end else begin
            pend_cyc  = c + AC;
            pend_data = ref_rd(pa[mp]);
          end
          mp++;
        end
      end
      check($sformatf("%s_gnt_c%0d", tag, c), {bus.o_load_gnt, bus.o_proc_gnt}, exp_g);
      check($sformatf("%s_rvalid_c%0d", tag, c), bus.o_proc_rvalid, c == pend_cyc);
      if (c == pend_cyc) check($sformatf("%s_rdata_c%0d", tag, c), bus.o_proc_rdata, pend_data);
      if (bus.o_load_gnt) begin
        li++;
        if (li < n_l) begin
          bus.i_load_addr = la[li]; bus.i_load_wdata = ld[li];
        end else bus.i_load_req = 1'b0;
      end
      if (bus.o_proc_gnt) begin
        pi++;
        if (pi < n_p) begin
          bus.i_proc_addr = pa[pi]; bus.i_proc_wdata = pd[pi]; bus.i_proc_we = pw[pi];
        end else bus.i_proc_req = 1'b0;
      end
    end
    bus.i_load_req = 1'b0;
    bus.i_proc_req = 1'b0;
    check({tag, "_load_count"}, li, n_l);
    check({tag, "_proc_count"}, pi, n_p);
    check({tag, "_idle"}, bus.o_busy, 1'b0);
    foreach (touched[i]) check($sformatf("%s_mem_%0h", tag, touched[i]), sram_rd(touched[i]), ref_rd(touched[i]));
  endtask

  initial begin
    logic [2:0] exp3;
    bus.i_disp_req = 1'b1; bus.i_disp_addr = 20'h00111;
    bus.i_load_req = 1'b1; bus.i_load_addr = 20'h00222; bus.i_load_wdata = 16'h3333;
    bus.i_proc_req = 1'b1; bus.i_proc_addr = 20'h00444; bus.i_proc_wdata = 16'h5555;
    bus.i_proc_we  = 1'b1;
    bus.i_sram_dq  = 16'hDEAD;
    sram_mem[20'h12345] = 16'hBEEF;

    // Reset with every request held high
    for (int c = 1; c <= 3; c++) begin
      step();
      check_reset_pins($sformatf("reset_c%0d", c));
    end
    bus.i_disp_req = 1'b0; bus.i_load_req = 1'b0; bus.i_proc_req = 1'b0;
    rst = 1'b0;
    rr_fav = 1'b0;
    step();
    check("idle_after_reset", bus.o_busy, 1'b0);

    // All three at once: display, loader, processor at cycles 1, 4, 7
    bus.i_disp_req = 1'b1; bus.i_disp_addr = 20'h00020;
    bus.i_load_req = 1'b1; bus.i_load_addr = 20'h00030; bus.i_load_wdata = 16'h7777;
    bus.i_proc_req = 1'b1; bus.i_proc_addr = 20'h00030; bus.i_proc_we = 1'b0;
    ref_mem[20'h00030] = 16'h7777;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp3 = (c == 1) ? 3'b100 : (c == 4) ? 3'b010 : (c == 7) ? 3'b001 : 3'b000;
      check($sformatf("tri_gnt_c%0d", c), {bus.o_disp_gnt, bus.o_load_gnt, bus.o_proc_gnt}, exp3);
      check($sformatf("tri_rvalid_c%0d", c), {bus.o_disp_rvalid, bus.o_proc_rvalid},
            (c == 3) ? 2'b10 : (c == 9) ? 2'b01 : 2'b00);
      if (c == 3) check("tri_disp_rdata", bus.o_disp_rdata, ref_rd(20'h00020));
      if (c == 9) check("tri_proc_rdata", bus.o_proc_rdata, 16'h7777);
      if (bus.o_disp_gnt) bus.i_disp_req = 1'b0;
      if (bus.o_load_gnt) bus.i_load_req = 1'b0;
      if (bus.o_proc_gnt) bus.i_proc_req = 1'b0;
    end
    rr_fav = 1'b0;

    // Display read returning 0xBEEF
    bus.i_disp_req = 1'b1; bus.i_disp_addr = 20'h12345;
    step();
    check("disp_gnt_c1", bus.o_disp_gnt, 1'b1);
    check("disp_pins_c1", {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_dq_oe}, 4'b0010);
    check("disp_addr_c1", bus.o_sram_addr, 20'h12345);
    bus.i_disp_req = 1'b0;
    step();
    check("disp_oe_c2", {bus.o_sram_oe_n, bus.o_disp_rvalid}, 2'b00);
    step();
    check("disp_rvalid_c3", {bus.o_disp_rvalid, bus.o_sram_oe_n}, 2'b11);
    check("disp_rdata_c3", bus.o_disp_rdata, 16'hBEEF);
    step();
    check("disp_c4", {bus.o_disp_rvalid, bus.o_busy}, 2'b00);
    check("disp_rdata_hold", bus.o_disp_rdata, 16'hBEEF);

    // Loader and processor continuous, processor reads: L,P,L,P,L,P
    run_lp("alt", 3, 3, 1'b1, 20'h40000);

    // Single loader write 0x00AB to 0x00005
    bus.i_load_req = 1'b1; bus.i_load_addr = 20'h00005; bus.i_load_wdata = 16'h00AB;
    step();
    check("lw_gnt_c1", bus.o_load_gnt, 1'b1);
    check("lw_pins_c1", {bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n, bus.o_sram_dq_oe, bus.o_busy}, 5'b01011);
    check("lw_bus_c1", {bus.o_sram_addr, bus.o_sram_dq}, {20'h00005, 16'h00AB});
    bus.i_load_req = 1'b0;
    rr_fav = 1'b1;
    ref_mem[20'h00005] = 16'h00AB;
    step();
    check("lw_pins_c2", {bus.o_sram_we_n, bus.o_sram_dq_oe, bus.o_load_gnt}, 3'b010);
    step();
    check("lw_pins_c3", {bus.o_sram_ce_n, bus.o_sram_we_n, bus.o_sram_dq_oe}, 3'b011);
    check("lw_bus_c3", {bus.o_sram_addr, bus.o_sram_dq}, {20'h00005, 16'h00AB});
    step();
    check("lw_idle_c4", {bus.o_sram_ce_n, bus.o_sram_dq_oe, bus.o_busy}, 3'b100);
    check("lw_mem", sram_rd(20'h00005), 16'h00AB);

    // Random mix of loader writes and processor reads/writes
    run_lp("mix", int'($urandom_range(2, 5)), int'($urandom_range(2, 5)), 1'b0, 20'h50000);

    // Reset in the second ACCESS cycle of a processor write
    bus.i_proc_req = 1'b1; bus.i_proc_we = 1'b1; bus.i_proc_addr = 20'h0ABCD; bus.i_proc_wdata = 16'h1234;
    step();
    check("rst_wr_gnt_c1", bus.o_proc_gnt, 1'b1);
    bus.i_proc_req = 1'b0;
    step();
    check("rst_wr_we_c2", bus.o_sram_we_n, 1'b0);
    rst = 1'b1;
    step();
    check("rst_wr_pins", {bus.o_sram_we_n, bus.o_sram_ce_n, bus.o_sram_dq_oe, bus.o_busy}, 4'b1100);
    rst = 1'b0;
    rr_fav = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("rst_no_rvalid_c%0d", c), {bus.o_proc_rvalid, bus.o_disp_rvalid, bus.o_busy}, 3'b000);
    end
    run_lp("post_rst", 1, 1, 1'b1, 20'h60000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 1M×16 external SRAM among three requesters: the VGA display reader, the UART image loader, and the image-processing engine. Each transaction is one word, and the block serialises them with fixed display priority and round-robin between the loader and the processor. It owns every SRAM pin; no other block drives the SRAM. It sits between the requester blocks and the top-level SRAM tri-state buffer.

## Interface
- ACCESS_CYCLES, 2, cycles the SRAM strobes (WE_N/OE_N) stay active per transaction; legal range 1..15
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, synchronous, active-high (named as in the codebase; asserted = 1)
- i_disp_req / i_disp_addr  in  1 / 20  display read request and word address
- o_disp_gnt  out  1  one-cycle grant pulse
- o_disp_rvalid / o_disp_rdata  out  1 / 16  read-data pulse and data
- i_load_req / i_load_addr / i_load_wdata  in  1 / 20 / 16  loader write request
- o_load_gnt  out  1  grant pulse
- i_proc_req / i_proc_we / i_proc_addr / i_proc_wdata  in  1 / 1 / 20 / 16  processor request; we=1 means write
- o_proc_gnt  out  1  grant pulse
- o_proc_rvalid / o_proc_rdata  out  1 / 16  processor read-data pulse and data
- o_sram_addr  out  20  SRAM address
- o_sram_dq / o_sram_dq_oe / i_sram_dq  out / out / in  16 / 1 / 16  split data bus; the top level builds the tri-state
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM controls
- o_busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, TURN.
  - IDLE → ACCESS when any request is present at the clock edge.
  - ACCESS holds for ACCESS_CYCLES cycles, tracked by a 4-bit counter from 0 to ACCESS_CYCLES-1, then goes to TURN.
  - TURN → ACCESS when any request is present, otherwise TURN → IDLE.
- Arbitration is evaluated only in IDLE and TURN.
  - Display wins whenever it requests.
  - Otherwise the loader and the processor alternate using a 1-bit round-robin pointer that favours the loader after reset.
  - The pointer flips to the other requester after each loader or processor grant.
  - A lone requester always wins.
- On the winning edge the block latches the address, write data, we bit (loader = 1, display = 0) and winner id into registers. SRAM pins are driven only from these registers.
- Requester rules:
  - Hold req, addr and wdata stable until gnt is seen.
  - Deassert req the cycle after gnt, unless the next request is already valid.
  - Requests are never dropped or merged.
- SRAM pins by phase:
  - IDLE: ce_n = oe_n = we_n = 1, lb_n = ub_n = 1, dq_oe = 0.
  - ACCESS: ce_n = 0, lb_n = ub_n = 0.
  - ACCESS, read: oe_n = 0.
  - ACCESS, write: we_n = 0, dq_oe = 1.
  - TURN: we_n = 1 and oe_n = 1. Address, ce_n, dq and dq_oe are held from ACCESS to give address/data hold time after WE_N rises.
- Read data is sampled from i_sram_dq at the edge that ends the last ACCESS cycle. It is presented on the winner's rdata with a one-cycle rvalid during TURN.
- rdata registers keep their last value between reads.

## Timing
- Reset values: all *_n outputs = 1, o_sram_dq_oe = 0, o_sram_addr = 0, o_sram_dq = 0, all gnt and rvalid = 0, all rdata = 0, o_busy = 0, rr pointer = loader, state = IDLE.
- Request sampled at edge E: gnt is high in cycle E+1, which is the first ACCESS cycle.
- ACCESS spans cycles E+1 .. E+ACCESS_CYCLES. TURN and rvalid fall in cycle E+ACCESS_CYCLES+1.
- Back-to-back transactions occupy ACCESS_CYCLES+1 cycles each (3 at the default) with no IDLE cycle between them.
- At most one gnt and one rvalid are high in any cycle.
- If a request arrives during ACCESS, it is served at the next TURN.
- Reset asserted in any state: all outputs take their reset values at the next edge. The in-flight transaction is aborted with no rvalid; a write may be partially performed.
- Display starvation of the other requesters is permitted by design.

## Test plan
- Reset: hold i_rst_n = 1 for 3 cycles with all requests high. Required: every output at its reset value and no gnt.
- Single loader write, addr 0x00005, data 0x00AB, sampled at edge 0:
  - o_load_gnt = 1 in cycle 1.
  - we_n = 0 in cycles 1–2; addr = 0x00005, dq = 0x00AB, dq_oe = 1 in cycles 1–3.
  - we_n = 1 in cycle 3; back in IDLE with dq_oe = 0 in cycle 4.
- Display read, addr 0x12345, SRAM model returns 0xBEEF: gnt in cycle 1, oe_n = 0 in cycles 1–2, o_disp_rvalid = 1 with o_disp_rdata = 0xBEEF in cycle 3.
- All three requesters assert in the same cycle, each dropping req after its gnt. Required: grant order display, loader, processor, with gnts in cycles 1, 4 and 7.
- Loader and processor hold req continuously for 6 grants, processor doing reads at distinct addresses. Required:
  - Grants alternate L, P, L, P, L, P, 3 cycles apart.
  - Each processor rvalid carries the model data for its own address.
- Reset asserted in the second ACCESS cycle of a processor write. Required: next cycle we_n = 1, ce_n = 1, dq_oe = 0, o_busy = 0; no rvalid follows; the next request after reset is granted normally.
